// File: rtl/ctrl_decode_pipe.sv
// RV32I main decoder plus a STAGES-deep control-bundle pipeline with stall/flush/valid.
// Optional illegal-instruction trap counter is enabled by defining ILLEGAL_TRAP_EN.
module ctrl_decode_pipe #(
  parameter int STAGES = 3,
  parameter int CNT_W  = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [6:0]            op,
  input  logic [2:0]            funct3,
  input  logic                  valid_d,
  input  logic                  stall,
  input  logic                  flush_e,
  output logic [2:0]            imm_src_d,
  output logic [14*STAGES-1:0]  ctrl_q,
  output logic [1:0]            alu_src_a_e,
  output logic                  alu_src_b_e,
  output logic [1:0]            alu_op_e,
  output logic                  branch_e,
  output logic                  branch_inv_e,
  output logic                  jump_e,
  output logic                  jalr_e,
  output logic                  mem_write_m,
  output logic                  reg_write_m,
  output logic                  reg_write_w,
  output logic [1:0]            result_src_w,
  output logic                  illegal_d,
  output logic                  illegal_seen,
  output logic [CNT_W-1:0]      illegal_cnt
);

  typedef struct packed {
    logic       valid;
    logic       reg_write;
    logic [1:0] result_src;
    logic       mem_write;
    logic       jump;
    logic       jalr;
    logic       branch;
    logic       branch_inv;
    logic [1:0] alu_src_a;
    logic       alu_src_b;
    logic [1:0] alu_op;
  } ctrl_t;

  ctrl_t                dec, bundle_d;
  logic [2:0]           imm_dec;
  logic                 known, live;
  ctrl_t [STAGES-1:0]   stg;

  always_comb begin
    dec     = '0;
    imm_dec = 3'b000;
    known   = 1'b1;
    unique case (op)
      7'b0000011: begin dec.reg_write = 1'b1; dec.result_src = 2'b01; dec.alu_src_b = 1'b1; end
      7'b0100011: begin dec.mem_write = 1'b1; dec.alu_src_b = 1'b1; imm_dec = 3'b001; end
      7'b0110011: begin dec.reg_write = 1'b1; dec.alu_op = 2'b10; end
      7'b0010011: begin dec.reg_write = 1'b1; dec.alu_src_b = 1'b1; dec.alu_op = 2'b10; end
      7'b1100011: begin
        // only beq (000) and bne (001) are supported
        known          = (funct3[2:1] == 2'b00);
        dec.branch     = 1'b1;
        dec.branch_inv = funct3[0];
        dec.alu_op     = 2'b01;
        imm_dec        = 3'b010;
      end
      7'b1101111: begin dec.reg_write = 1'b1; dec.result_src = 2'b10; dec.jump = 1'b1; imm_dec = 3'b011; end
      7'b1100111: begin
        known          = (funct3 == 3'b000);
        dec.reg_write  = 1'b1;
        dec.result_src = 2'b10;
        dec.jalr       = 1'b1;
        dec.alu_src_b  = 1'b1;
      end
      7'b0110111: begin dec.reg_write = 1'b1; dec.alu_src_a = 2'b01; dec.alu_src_b = 1'b1; imm_dec = 3'b100; end
      7'b0010111: begin dec.reg_write = 1'b1; dec.alu_src_a = 2'b10; dec.alu_src_b = 1'b1; imm_dec = 3'b100; end
      7'b0000000: known = 1'b1;
      default:    known = 1'b0;
    endcase
  end

  // Anything not a valid, legal, non-zero instruction collapses to the all-zero bubble.
  assign live      = valid_d & known & (op != 7'b0000000);
  assign bundle_d  = live ? {1'b1, dec[12:0]} : '0;
  assign imm_src_d = live ? imm_dec : 3'b000;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stg <= '0;
    end else begin
      if (!stall)
        for (int k = 1; k < STAGES; k++) stg[k] <= stg[k-1];
      if (flush_e)     stg[0] <= '0;
      else if (!stall) stg[0] <= bundle_d;
    end
  end

  assign ctrl_q       = stg;
  assign alu_src_a_e  = stg[0].alu_src_a;
  assign alu_src_b_e  = stg[0].alu_src_b;
  assign alu_op_e     = stg[0].alu_op;
  assign branch_e     = stg[0].branch;
  assign branch_inv_e = stg[0].branch_inv;
  assign jump_e       = stg[0].jump;
  assign jalr_e       = stg[0].jalr;
  assign mem_write_m  = stg[1].mem_write & stg[1].valid;
  assign reg_write_m  = stg[1].reg_write & stg[1].valid;
  assign reg_write_w  = stg[STAGES-1].reg_write & stg[STAGES-1].valid;
  assign result_src_w = stg[STAGES-1].result_src;

`ifdef ILLEGAL_TRAP_EN
  logic cap;
  assign illegal_d = valid_d & ~known;
  // flushed or stalled illegal instructions are not counted
  assign cap = illegal_d & ~stall & ~flush_e;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      illegal_seen <= 1'b0;
      illegal_cnt  <= '0;
    end else if (cap) begin
      illegal_seen <= 1'b1;
      if (illegal_cnt != {CNT_W{1'b1}}) illegal_cnt <= illegal_cnt + CNT_W'(1);
    end
  end
`else
  assign illegal_d    = 1'b0;
  assign illegal_seen = 1'b0;
  assign illegal_cnt  = '0;
`endif

endmodule

// File: tb/tb_ctrl_decode_pipe.sv
// Self-checking bench for ctrl_decode_pipe: directed scenarios plus randomized traffic
// compared each cycle against a table-driven reference model.
module tb_ctrl_decode_pipe;
  localparam int STAGES = 3;
  localparam int CNT_W  = 2;
`ifdef ILLEGAL_TRAP_EN
  localparam bit EN = 1'b1;
`else
  localparam bit EN = 1'b0;
`endif
  localparam int CMAX = (1 << CNT_W) - 1;

  logic clk = 1'b0, reset = 1'b1;
  logic [6:0] op = '0;
  logic [2:0] funct3 = '0;
  logic valid_d = 1'b0, stall = 1'b0, flush_e = 1'b0;
  logic [2:0] imm_src_d;
  logic [14*STAGES-1:0] ctrl_q;
  logic [1:0] alu_src_a_e, alu_op_e, result_src_w;
  logic alu_src_b_e, branch_e, branch_inv_e, jump_e, jalr_e;
  logic mem_write_m, reg_write_m, reg_write_w, illegal_d, illegal_seen;
  logic [CNT_W-1:0] illegal_cnt;

  ctrl_decode_pipe #(.STAGES(STAGES), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .valid_d(valid_d),
    .stall(stall), .flush_e(flush_e), .imm_src_d(imm_src_d), .ctrl_q(ctrl_q),
    .alu_src_a_e(alu_src_a_e), .alu_src_b_e(alu_src_b_e), .alu_op_e(alu_op_e),
    .branch_e(branch_e), .branch_inv_e(branch_inv_e), .jump_e(jump_e), .jalr_e(jalr_e),
    .mem_write_m(mem_write_m), .reg_write_m(reg_write_m), .reg_write_w(reg_write_w),
    .result_src_w(result_src_w), .illegal_d(illegal_d), .illegal_seen(illegal_seen),
    .illegal_cnt(illegal_cnt));

  always #5 clk = ~clk;

  int n_pass = 0, n_tot = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Returns {illegal, imm_src, bundle} straight from the decode table.
  function automatic logic [17:0] model_dec(input logic [6:0] o, input logic [2:0] f, input logic v);
    logic rw, mw, j, jr, br, bi, sb;
    logic [1:0] rs, sa, aop;
    logic [2:0] imm;
    bit ok, lv;
    rw = 0; mw = 0; j = 0; jr = 0; br = 0; bi = 0; sb = 0;
    rs = 0; sa = 0; aop = 0; imm = 0; ok = 1;
    case (o)
      7'h03: begin rw = 1; rs = 1; sb = 1; end
      7'h23: begin mw = 1; sb = 1; imm = 1; end
      7'h33: begin rw = 1; aop = 2; end
      7'h13: begin rw = 1; sb = 1; aop = 2; end
      7'h63: if (f == 0 || f == 1) begin br = 1; bi = f[0]; aop = 1; imm = 2; end else ok = 0;
      7'h6F: begin rw = 1; rs = 2; j = 1; imm = 3; end
      7'h67: if (f == 0) begin rw = 1; rs = 2; jr = 1; sb = 1; end else ok = 0;
      7'h37: begin rw = 1; sa = 1; sb = 1; imm = 4; end
      7'h17: begin rw = 1; sa = 2; sb = 1; imm = 4; end
      7'h00: ok = 1;
      default: ok = 0;
    endcase
    lv = v && ok && (o != 0);
    return {EN && v && !ok, lv ? imm : 3'b000,
            lv ? {1'b1, rw, rs, mw, j, jr, br, bi, sa, sb, aop} : 14'b0};
  endfunction

  logic [13:0] m_stg [STAGES];
  int m_cnt;
  bit m_seen;
  initial begin
    for (int k = 0; k < STAGES; k++) m_stg[k] = '0;
    m_cnt = 0; m_seen = 0;
  end

  always @(posedge clk or negedge reset) begin
    logic [17:0] d;
    if (!reset) begin
      for (int k = 0; k < STAGES; k++) m_stg[k] <= '0;
      m_cnt <= 0; m_seen <= 0;
    end else begin
      d = model_dec(op, funct3, valid_d);
      if (!(stall && !flush_e)) begin
        m_stg[0] <= flush_e ? 14'b0 : d[13:0];
        if (!stall)
          for (int k = 1; k < STAGES; k++) m_stg[k] <= m_stg[k-1];
      end
      if (d[17] && !stall && !flush_e) begin
        m_seen <= 1;
        m_cnt  <= (m_cnt < CMAX) ? m_cnt + 1 : CMAX;
      end
    end
  end

  always @(negedge clk) if (chk_en) begin
    logic [14*STAGES-1:0] eq;
    logic [17:0] d;
    for (int k = 0; k < STAGES; k++) eq[14*k +: 14] = m_stg[k];
    d = model_dec(op, funct3, valid_d);
    chk("ctrl_q", 64'(ctrl_q), 64'(eq));
    chk("imm_src_d", 64'(imm_src_d), 64'(d[16:14]));
    chk("illegal_d", 64'(illegal_d), 64'(d[17]));
    chk("alu_src_a_e", 64'(alu_src_a_e), 64'(m_stg[0][4:3]));
    chk("alu_src_b_e", 64'(alu_src_b_e), 64'(m_stg[0][2]));
    chk("alu_op_e", 64'(alu_op_e), 64'(m_stg[0][1:0]));
    chk("ctl_flags_e", 64'({branch_e, branch_inv_e, jump_e, jalr_e}),
        64'({m_stg[0][6], m_stg[0][5], m_stg[0][8], m_stg[0][7]}));
    chk("mem_write_m", 64'(mem_write_m), 64'(m_stg[1][9] & m_stg[1][13]));
    chk("reg_write_m", 64'(reg_write_m), 64'(m_stg[1][12] & m_stg[1][13]));
    chk("reg_write_w", 64'(reg_write_w), 64'(m_stg[STAGES-1][12] & m_stg[STAGES-1][13]));
    chk("result_src_w", 64'(result_src_w), 64'(m_stg[STAGES-1][11:10]));
    chk("illegal_seen", 64'(illegal_seen), 64'(m_seen));
    chk("illegal_cnt", 64'(illegal_cnt), 64'(m_cnt));
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic drv(input logic [6:0] o, input logic [2:0] f, input logic v,
                     input logic s, input logic fl);
    op = o; funct3 = f; valid_d = v; stall = s; flush_e = fl; #1;
  endtask

  localparam logic [13:0] B_LW = 14'h3404, B_SW = 14'h2204, B_R = 14'h3002;
  logic [6:0] ops [12] = '{7'h03, 7'h23, 7'h33, 7'h13, 7'h63, 7'h6F,
                          7'h67, 7'h37, 7'h17, 7'h00, 7'h7F, 7'h0B};

  initial begin
    #2 reset = 1'b0;
    #1 chk_en = 1'b1;
    chk("rst_ctrl_q", 64'(ctrl_q), 64'd0);
    chk("rst_cnt", 64'({illegal_seen, illegal_cnt}), 64'd0);
    tick(); tick();
    reset = 1'b1;

    // T1: fill with lw, then reset mid-stream
    drv(7'h03, 0, 1, 0, 0);
    tick(); tick(); tick();
    chk("t1_full", 64'(ctrl_q), 64'({B_LW, B_LW, B_LW}));
    reset = 1'b0; #1;
    chk("t1_async_clr", 64'(ctrl_q), 64'd0);
    tick();
    chk("t1_held", 64'({ctrl_q, reg_write_w}), 64'd0);
    reset = 1'b1;
    tick();
    chk("t1_e1_srcb", 64'(alu_src_b_e), 64'd1);
    drv(0, 0, 0, 0, 0);
    tick(); tick();
    chk("t1_e3_w", 64'({reg_write_w, result_src_w}), 64'b1_01);

    // T2: sw, bne, jalr, auipc back to back
    drv(7'h23, 0, 1, 0, 0);
    chk("t2_imm_sw", 64'(imm_src_d), 64'd1);
    tick();
    chk("t2_sw_mw", 64'(ctrl_q[9]), 64'd1);
    drv(7'h63, 1, 1, 0, 0);
    chk("t2_imm_bne", 64'(imm_src_d), 64'd2);
    tick();
    chk("t2_bne", 64'({branch_e, branch_inv_e, alu_op_e}), 64'b1_1_01);
    chk("t2_sw_m", 64'(mem_write_m), 64'd1);
    drv(7'h67, 0, 1, 0, 0);
    chk("t2_imm_jalr", 64'(imm_src_d), 64'd0);
    tick();
    chk("t2_jalr", 64'({jalr_e, ctrl_q[11:10]}), 64'b1_10);
    drv(7'h17, 0, 1, 0, 0);
    chk("t2_imm_auipc", 64'(imm_src_d), 64'd4);
    tick();
    chk("t2_auipc", 64'({alu_src_a_e, alu_src_b_e}), 64'b10_1);

    // T3: stall+flush bubbles stage 1 only
    drv(7'h33, 0, 1, 0, 0); tick();
    drv(7'h23, 0, 1, 0, 0); tick();
    drv(7'h03, 0, 1, 0, 0); tick();
    drv(7'h6F, 0, 1, 1, 1); tick();
    chk("t3_stall_flush", 64'(ctrl_q), 64'({B_R, B_SW, 14'h0}));
    drv(0, 0, 0, 0, 0); tick();
    chk("t3_resume", 64'(ctrl_q), 64'({B_SW, 14'h0, 14'h0}));

    // T4/T5: illegal branch funct3, flush suppression, saturation
    drv(7'h63, 3'b010, 1, 0, 0);
    chk("t4_illegal_d", 64'(illegal_d), 64'(EN));
    tick();
    chk("t4_bubble", 64'(ctrl_q[13:0]), 64'd0);
    chk("t4_cnt1", 64'({illegal_seen, illegal_cnt}), 64'({EN, CNT_W'(EN)}));
    drv(7'h63, 3'b010, 1, 0, 1); tick();
    chk("t4_flush_cnt", 64'(illegal_cnt), 64'(EN));
    drv(7'h63, 3'b010, 1, 0, 0);
    repeat (5) tick();
    chk("t5_sat", 64'(illegal_cnt), EN ? 64'd3 : 64'd0);

    // T6: invalid lw and opcode 0
    drv(7'h03, 0, 0, 0, 0); tick();
    chk("t6_inv", 64'(ctrl_q[13:0]), 64'd0);
    drv(0, 0, 1, 0, 0);
    chk("t6_zero_ill", 64'({illegal_d, imm_src_d}), 64'd0);
    tick(); tick();
    chk("t6_rw_w", 64'(reg_write_w), 64'd0);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      tick();
      if ($urandom_range(0, 99) == 0) begin reset = 1'b0; #1 reset = 1'b1; end
      drv(ops[$urandom_range(0, 11)], 3'($urandom_range(0, 7)),
          $urandom_range(0, 9) < 8, $urandom_range(0, 9) < 2, $urandom_range(0, 19) < 3);
    end
    tick();
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
